// File: rtl/trace_pkg.sv
// Shared types and entry layout for the commit trace buffer.
// An entry packs {pc, inst, wb_en, wb_addr, wb_data}, wb_data at bit 0.
package trace_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int ENTRY_W = 3 * DATA_W + 1 + REG_AW;

  localparam int OFF_WB_DATA = 0;
  localparam int OFF_WB_ADDR = OFF_WB_DATA + DATA_W;
  localparam int OFF_WB_EN = OFF_WB_ADDR + REG_AW;
  localparam int OFF_INST = OFF_WB_EN + 1;
  localparam int OFF_PC = OFF_INST + DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/trace_capture_buffer_if.sv
// Commit-in and drain-out bundles of the trace buffer.
// slave is the buffer side, master is the CPU/consumer side.
interface trace_capture_buffer_if;
  import trace_pkg::*;

  logic              commit_valid;
  logic [DATA_W-1:0] commit_pc;
  logic [DATA_W-1:0] commit_inst;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;
  logic [DATA_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_inst;
  logic              rd_wb_en;
  logic [REG_AW-1:0] rd_wb_addr;
  logic [DATA_W-1:0] rd_wb_data;

  modport master (
    output commit_valid, commit_pc, commit_inst,
    output wb_en, wb_addr, wb_data, rd_ready,
    input  rd_valid, rd_last, rd_pc, rd_inst,
    input  rd_wb_en, rd_wb_addr, rd_wb_data
  );

  modport slave (
    input  commit_valid, commit_pc, commit_inst,
    input  wb_en, wb_addr, wb_data, rd_ready,
    output rd_valid, rd_last, rd_pc, rd_inst,
    output rd_wb_en, rd_wb_addr, rd_wb_data
  );

endinterface

// File: rtl/trace_ram.sv
// Simple dual-port trace RAM: sync write, registered sync read.
// Contents are never cleared.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6,
  parameter int WIDTH = 101
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/trace_capture_buffer.sv
// Commit trace capture: circular buffer, free-run or PC trigger,
// drained oldest-first over a valid/ready stream.
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6,
  parameter int POST_TRIG = 16
) (
  input  logic                clk_in,
  input  logic                reset,
  trace_capture_buffer_if.slave tif,
  input  logic                mode,
  input  logic [DATA_W-1:0]   trig_pc,
  input  logic                arm,
  input  logic                stop,
  output logic                busy,
  output logic                triggered,
  output logic                wrapped,
  output logic [ADDR_W:0]     entry_count
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] PT = (ADDR_W + 1)'(POST_TRIG);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W:0] post_cnt_q, post_cnt_d;
  logic mode_q, mode_d;
  logic [DATA_W-1:0] trig_pc_q, trig_pc_d;
  logic trig_q, trig_d;
  logic wrap_q, wrap_d;
  logic busy_q, busy_d;
  logic rd_valid_q, rd_valid_d;
  logic rd_last_q, rd_last_d;
  logic ram_ok_q, ram_ok_d;
  logic [ENTRY_W-1:0] out_q, out_d;

  logic we, hit, accept, load;
  logic [ENTRY_W-1:0] wdata, ram_dout;

  assign wdata = {tif.commit_pc, tif.commit_inst,
                  tif.wb_en, tif.wb_addr, tif.wb_data};
  assign hit = mode_q && tif.commit_valid &&
               (tif.commit_pc == trig_pc_q);
  assign accept = rd_valid_q && tif.rd_ready;

  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d = cnt_q;
    post_cnt_d = post_cnt_q;
    mode_d = mode_q;
    trig_pc_d = trig_pc_q;
    trig_d = trig_q;
    wrap_d = wrap_q;
    we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          wr_ptr_d = '0;
          cnt_d = '0;
          post_cnt_d = '0;
          trig_d = 1'b0;
          wrap_d = 1'b0;
          mode_d = mode;
          trig_pc_d = trig_pc;
        end
      end
      ARMED, POST: begin
        if (tif.commit_valid) begin
          we = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (cnt_q == FULL) wrap_d = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        end
        if (state_q == ARMED) begin
          if (hit) begin
            trig_d = 1'b1;
            post_cnt_d = PT;
            state_d = (POST_TRIG == 0) ? DRAIN : POST;
          end
        end else if (tif.commit_valid) begin
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == ONE) state_d = DRAIN;
        end
        if (stop) state_d = DRAIN;
        // oldest entry sits entry_count behind the write pointer
        if (state_d == DRAIN)
          rd_ptr_d = wr_ptr_d - cnt_d[ADDR_W-1:0];
      end
      DRAIN: begin
        if (accept) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
        if (cnt_q == '0 || (accept && cnt_q == ONE))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM reads rd_ptr_d, so its output tracks rd_ptr_q one cycle
  // later; the first DRAIN cycle may still see a stale read.
  always_comb begin
    ram_ok_d = (state_q == DRAIN);
    load = (state_q == DRAIN) && !rd_valid_q &&
           (cnt_q != '0) && ram_ok_q;
    rd_valid_d = rd_valid_q ? !accept : load;
    out_d = load ? ram_dout : out_q;
    rd_last_d = rd_valid_d && (cnt_d == ONE);
    busy_d = (state_d == ARMED) || (state_d == POST);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      post_cnt_q <= '0;
      mode_q <= 1'b0;
      trig_pc_q <= '0;
      trig_q <= 1'b0;
      wrap_q <= 1'b0;
      busy_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q <= 1'b0;
      ram_ok_q <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      post_cnt_q <= post_cnt_d;
      mode_q <= mode_d;
      trig_pc_q <= trig_pc_d;
      trig_q <= trig_d;
      wrap_q <= wrap_d;
      busy_q <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q <= rd_last_d;
      ram_ok_q <= ram_ok_d;
      out_q <= out_d;
    end
  end

  trace_ram #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .WIDTH(ENTRY_W)
  ) u_ram (
    .clk(clk_in),
    .we(we),
    .waddr(wr_ptr_q),
    .wdata(wdata),
    .raddr(rd_ptr_d),
    .rdata(ram_dout)
  );

  assign busy = busy_q;
  assign triggered = trig_q;
  assign wrapped = wrap_q;
  assign entry_count = cnt_q;
  assign tif.rd_valid = rd_valid_q;
  assign tif.rd_last = rd_last_q;
  assign tif.rd_pc = out_q[OFF_PC +: DATA_W];
  assign tif.rd_inst = out_q[OFF_INST +: DATA_W];
  assign tif.rd_wb_en = out_q[OFF_WB_EN];
  assign tif.rd_wb_addr = out_q[OFF_WB_ADDR +: REG_AW];
  assign tif.rd_wb_data = out_q[OFF_WB_DATA +: DATA_W];

endmodule
